// File: rtl/fft_frame_ctrl.sv
// Front-end controller for a radix-2 burst FFT core: frames a continuous sample
// stream with tlast and issues config beats only at frame boundaries.
module fft_frame_ctrl #(
  parameter int DATA_WIDTH    = 24,
  parameter int N_FFT_MIN     = 9,
  parameter int N_FFT_MAX     = 12,
  parameter int N_FFT_DEFAULT = 9,
  parameter int CFG_WIDTH     = 8 * ((17 + 2 * N_FFT_MAX + 7) / 8)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2*DATA_WIDTH-1:0] s_data_data,
  input  logic                    s_data_valid,
  output logic                    s_data_ready,
  output logic [2*DATA_WIDTH-1:0] m_data_data,
  output logic                    m_data_valid,
  input  logic                    m_data_ready,
  output logic                    m_data_last,
  output logic [CFG_WIDTH-1:0]    m_cfg_data,
  output logic                    m_cfg_valid,
  input  logic                    m_cfg_ready,
  input  logic                    req_valid,
  input  logic [4:0]              req_nfft,
  input  logic                    req_fwd,
  input  logic [2*N_FFT_MAX-1:0]  req_scale,
  output logic                    cfg_busy,
  output logic                    cfg_err,
  output logic [31:0]             frame_count
);

  localparam int CNT_W   = N_FFT_MAX;
  localparam int SCALE_W = 2 * N_FFT_MAX;
  localparam logic [SCALE_W-1:0] SCALE_DEFAULT = {{(N_FFT_MAX-1){2'b01}}, 2'b10};

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_PEND, ST_CFG} state_e;

  typedef struct packed {
    logic [4:0]         nfft;
    logic               fwd;
    logic [SCALE_W-1:0] scale;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{nfft: 5'(N_FFT_DEFAULT), fwd: 1'b1, scale: SCALE_DEFAULT};

  state_e            state_q, state_d;
  cfg_t              act_q, act_d;
  cfg_t              pend_q, pend_d;
  cfg_t              req;
  logic              pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_idx;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              cfg_vld_q, cfg_vld_d;
  logic              cfg_err_q, cfg_err_d;
  logic              gate;
  logic              data_hs;
  logic              cfg_hs;
  logic              nfft_in_range;
  logic              req_ok;

  assign req           = '{nfft: req_nfft, fwd: req_fwd, scale: req_scale};
  assign nfft_in_range = (req_nfft >= 5'(N_FFT_MIN)) && (req_nfft <= 5'(N_FFT_MAX));
  assign req_ok        = req_valid && nfft_in_range;

  // Low nfft bits set: index of the final sample in a frame of the active length.
  assign last_idx = ~({CNT_W{1'b1}} << act_q.nfft);

  assign m_data_data  = s_data_data;
  assign m_data_valid = s_data_valid & gate;
  assign s_data_ready = m_data_ready & gate;
  assign m_data_last  = gate & (cnt_q == last_idx);
  assign data_hs      = m_data_valid & m_data_ready;
  assign cfg_hs       = m_cfg_valid & m_cfg_ready;

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next-state and datapath update logic.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    cfg_err_d   = req_valid & ~nfft_in_range;

    if (data_hs) begin
      cnt_d = m_data_last ? '0 : cnt_q + CNT_W'(1);
      if (m_data_last) frame_cnt_d = frame_cnt_q + 32'd1;
    end

    unique case (state_q)
      ST_INIT, ST_CFG: begin
        if (req_ok) begin
          pend_d     = req;
          pend_vld_d = 1'b1;
        end
        if (cfg_hs) begin
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          state_d    = (req_ok || pend_vld_q) ? ST_PEND : ST_RUN;
        end
      end
      ST_RUN: begin
        if (req_ok) begin
          if (cnt_q == '0 && !data_hs) begin
            act_d   = req;
            state_d = ST_CFG;
          end else begin
            pend_d  = req;
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (req_ok) pend_d = req;
        // A request landing on the boundary cycle is the newest, so it wins.
        if (data_hs && m_data_last) begin
          act_d   = req_ok ? req : pend_q;
          state_d = ST_CFG;
        end
      end
      default: state_d = ST_INIT;
    endcase

    cfg_vld_d = (state_d == ST_INIT) || (state_d == ST_CFG);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q       <= CFG_RESET;
      pend_q      <= CFG_RESET;
      pend_vld_q  <= 1'b0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      cfg_vld_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_vld_q   <= cfg_vld_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Output logic; the config word only changes on entry to CFG, so it is
  // stable for as long as m_cfg_valid is held.
  always_comb begin
    gate        = (state_q == ST_RUN) || (state_q == ST_PEND);
    cfg_busy    = (state_q != ST_RUN);
    m_cfg_valid = cfg_vld_q;
    cfg_err     = cfg_err_q;
    frame_count = frame_cnt_q;

    m_cfg_data                   = '0;
    m_cfg_data[7:0]              = 8'(act_q.nfft);
    m_cfg_data[16]               = act_q.fwd;
    m_cfg_data[16+SCALE_W:17]    = act_q.scale;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Runtime-configurable front-end controller for the radix-2 burst XFFT core.
- Takes a continuous complex sample stream, generates per-frame tlast for the active transform length, and issues config beats on the core's config channel (NFFT, direction, scale schedule).
- A config beat is issued only at frame boundaries, so transform length, direction and scaling can change at runtime without a resynthesis.
- Sits between the ADC/window stage and the XFFT instance.

Parameters:
- DATA_WIDTH, 24, bits per I/Q component; sample bus is 2*DATA_WIDTH.
- N_FFT_MIN, 9, smallest log2 transform length accepted.
- N_FFT_MAX, 12, largest log2 transform length accepted (core built for this maximum).
- N_FFT_DEFAULT, 9, log2 length loaded after reset.
- CFG_WIDTH, 8*((17+2*N_FFT_MAX+7)/8), config bus width (48 for defaults).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- s_data_data  in  2*DATA_WIDTH  input sample {Q,I}
- s_data_valid  in  1  input valid
- s_data_ready  out  1  input ready
- m_data_data  out  2*DATA_WIDTH  sample to core
- m_data_valid  out  1  valid to core
- m_data_ready  in  1  core ready
- m_data_last  out  1  last sample of frame
- m_cfg_data  out  CFG_WIDTH  core config word
- m_cfg_valid  out  1  config valid
- m_cfg_ready  in  1  core config ready
- req_valid  in  1  one-cycle request for new configuration
- req_nfft  in  5  requested log2 length
- req_fwd  in  1  1 = forward transform
- req_scale  in  2*N_FFT_MAX  scale schedule, stage 0 in bits [1:0]
- cfg_busy  out  1  request pending or config beat in flight
- cfg_err  out  1  one-cycle pulse: request rejected
- frame_count  out  32  frames delivered to core

Behaviour:
- Reset (async assert, sync release): state INIT, active config = {N_FFT_DEFAULT, fwd=1, scale=default}. Default scale: stage 0 = 2'b10, all other stages = 2'b01. Sample counter 0, frame_count 0, cfg_err 0, m_cfg_valid 0, no pending request.
- Config word layout: [7:0] nfft; [15:8] zero (cyclic prefix unused); [16] fwd; [16+2*N_FFT_MAX:17] scale; upper bits zero.
- Data path is zero-latency combinational pass-through, gated by `gate`:
  - gate = 1 in RUN and PEND, 0 otherwise.
  - m_data_valid = s_data_valid & gate; s_data_ready = m_data_ready & gate; m_data_data = s_data_data.
  - m_data_last = gate & (cnt == 2^nfft_active - 1).
- Sample handshake: m_data_valid & m_data_ready. On handshake, cnt increments, wrapping to 0 when last is asserted; frame_count increments on a handshake with last asserted, wrapping at 2^32.
- m_cfg_data always presents the active config; it is held stable while m_cfg_valid=1.
- State machine:
  - INIT: m_cfg_valid=1; on m_cfg_ready -> RUN.
  - RUN: on a valid request: if cnt==0 and no sample handshake this cycle -> CFG (latch the request as active); otherwise latch it as pending -> PEND.
  - PEND: when a last-handshake occurs -> CFG, with the pending request made active the same cycle.
  - CFG: gate=0, m_cfg_valid=1; on m_cfg_ready -> RUN with cnt=0.
- Request validation: req_nfft outside [N_FFT_MIN, N_FFT_MAX] is dropped, produces a one-cycle cfg_err pulse, and causes no state change.
- New valid request in PEND: overwrites the pending request (last wins).
- Valid request in INIT or CFG: stored as pending; the FSM goes to PEND on entering RUN.
- cfg_busy = 1 whenever state != RUN.
- Reset mid-frame or mid-config: everything returns to reset values, and INIT re-sends the default config. A partial frame already in the core is the core's concern (it will flag tlast errors).

Test Plan:
- Reset, m_cfg_ready=1 -> one config beat with nfft=9, fwd=1, scale bits[1:0]=2'b10. Then 1024 continuous samples -> m_data_last on samples 511 and 1023, frame_count=2.
- Request nfft=10 at cnt=100 -> frames continue at 512 until sample 511. Then gate drops, config beat nfft=10, next frame last on its 1024th sample, cfg_busy high from request through config accept.
- Request nfft=8 and nfft=13 -> cfg_err pulses each time, no config beat, framing unchanged.
- Two requests in PEND (nfft=11, then nfft=12) -> a single config beat carrying nfft=12.
- m_cfg_ready held low for 20 cycles in CFG -> s_data_ready=0 throughout, m_cfg_data stable, no samples lost; random m_data_ready backpressure -> last position exact.
- Assert reset_n=0 at cnt=300 -> all outputs at reset values immediately, then INIT config beat with nfft=9 and cnt restarts at 0.
